ps2_key_decoder: RTL and testbench

- Receives the PS/2 keyboard clock/data lines and deserializes device-to-host frames (start, 8 data LSB-first, odd parity, stop).
- Folds Set-2 prefixes (E0 extended, F0 break) into the 11-bit ps2_key word that the keypad emulation consumes: bit 10 toggle, bit 9 pressed, bit 8 extended, bits 7:0 scan code.
- Sits between the keyboard pins and the console keypad-emulation logic, in the clk_i domain.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_line_filter.sv | 50 +++++
 rtl/ps2_key_decoder.sv | 149 ++++++++++++++
 tb/tb_ps2_key_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard decoder.
//   - ps2_state_t : frame receiver states
//   - Set-2 prefix / control byte codes
//   - is_ctrl_byte: bytes that carry no key information on their own
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_OVR0   = 8'h00;
    localparam logic [7:0] PS2_OVR1   = 8'hFF;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // BAT / ack / resend / echo / overrun replies from the keyboard.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return b inside {PS2_BAT, PS2_ACK, PS2_RESEND, PS2_ECHO, PS2_OVR0, PS2_OVR1};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one asynchronous PS/2 line.
//   clk       in  system clock
//   reset_n   in  asynchronous active-low reset
//   raw       in  raw pin level (asynchronous)
//   level     out filtered level (resets to 1, the idle bus level)
//   fall_edge out one-cycle strobe when level goes 1->0
// The filtered level only flips after FILTER_LEN consecutive synchronized
// samples at the opposite level; shorter excursions are discarded.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic fall_edge
);
    import ps2_pkg::*;

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            cnt       <= '0;
            level     <= 1'b1;
            fall_edge <= 1'b0;
        end else begin
            sync1     <= raw;
            sync2     <= sync1;
            fall_edge <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                // This is the FILTER_LEN-th opposite sample: commit it.
                cnt       <= '0;
                level     <= sync2;
                fall_edge <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver and Set-2 prefix folder.
//   clk_i      in  system clock
//   reset_n_i  in  asynchronous active-low reset
//   ps2_clk_i  in  raw PS/2 clock pin
//   ps2_dat_i  in  raw PS/2 data pin
//   ps2_key_o  out {toggle, pressed, extended, code[7:0]}
//   err_o      out one-cycle pulse on framing, parity or timeout error
// Pipeline: filtered clock fall of the stop bit (N) -> byte_valid /
// frame_err (N+1) -> ps2_key_o / err_o (N+2).
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 85909
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        ps2_clk_i,
    input  logic        ps2_dat_i,
    output logic [10:0] ps2_key_o,
    output logic        err_o
);
    import ps2_pkg::*;

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic          clk_lvl_unused;
    logic          clk_fall;
    logic          dat;
    logic          dat_fall_unused;

    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    sreg;
    logic          par;
    logic [TW-1:0] to_cnt;
    logic          byte_valid;
    logic          frame_err;

    logic          ext;
    logic          brk;
    logic [2:0]    pause_cnt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk       (clk_i),
        .reset_n   (reset_n_i),
        .raw       (ps2_clk_i),
        .level     (clk_lvl_unused),
        .fall_edge (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk       (clk_i),
        .reset_n   (reset_n_i),
        .raw       (ps2_dat_i),
        .level     (dat),
        .fall_edge (dat_fall_unused)
    );

    // Frame receiver. A clock fall always reloads the timeout counter, so it
    // takes priority over an expiry in the same cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            sreg       <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (clk_fall) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!dat) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        sreg    <= {dat, sreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par   <= dat;
                        state <= STOP;
                    end
                    STOP: begin
                        if (dat && (^{sreg, par})) begin
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

    // Byte processing. sreg is stable here: the next shift needs another
    // start bit plus a data bit, far beyond one cycle away.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ps2_key_o <= '0;
            err_o     <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            pause_cnt <= '0;
        end else begin
            err_o <= frame_err;
            if (frame_err) begin
                // Pause skip survives errors; prefixes do not.
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_valid) begin
                if (pause_cnt != '0) begin
                    pause_cnt <= pause_cnt - 1'b1;
                end else if (sreg == PS2_PAUSE) begin
                    pause_cnt <= PAUSE_SKIP;
                end else if (sreg == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (sreg == PS2_BRK) begin
                    brk <= 1'b1;
                end else if (!ext && !brk && is_ctrl_byte(sreg)) begin
                    // Keyboard housekeeping reply: no key event.
                end else begin
                    ps2_key_o <= {~ps2_key_o[10], ~brk, ext, sreg};
                    ext       <= 1'b0;
                    brk       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: scoreboard bench for ps2_key_decoder.
// Stimulus drives PS/2 frames and pushes expected events from a reference
// model; a monitor pops and compares on each ps2_key_o change / err_o pulse.
module tb_ps2_key_decoder;

    localparam int unsigned TO   = 2000;
    localparam int unsigned HALF = 20;

    logic        clk;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [10:0] key;
    logic        err;

    ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .ps2_clk_i (ps2_clk),
        .ps2_dat_i (ps2_dat),
        .ps2_key_o (key),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [10:0] key;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    bit   mon_en = 0;

    // Reference model state
    bit          m_ext, m_brk;
    int          m_skip;
    logic [10:0] m_key;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit is_housekeeping(input logic [7:0] b);
        logic [7:0] lst [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
        foreach (lst[i]) if (lst[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_ext = 0; m_brk = 0; m_skip = 0; m_key = '0;
    endfunction

    function automatic void model_err();
        exp_t e;
        m_ext = 0; m_brk = 0;
        e.is_err = 1; e.key = m_key;
        q.push_back(e);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        exp_t e;
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (!m_ext && !m_brk && is_housekeeping(b)) begin
        end else begin
            m_key = {~m_key[10], ~m_brk, m_ext, b};
            m_ext = 0; m_brk = 0;
            e.is_err = 0; e.key = m_key;
            q.push_back(e);
        end
    endfunction

    // Monitor
    logic [10:0] last_key;
    bit          prev_err;
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            last_key = key;
            prev_err = err;
        end else begin
            exp_t e;
            if (err) begin
                check_eq("err_pulse_width", 32'(prev_err), 0);
                if (!prev_err) begin
                    if (q.size() == 0) check_eq("spurious_err", 32'(err), 0);
                    else begin
                        e = q.pop_front();
                        check_eq("event_is_err", 32'(e.is_err), 1);
                    end
                end
            end
            if (key !== last_key) begin
                if (q.size() == 0) check_eq("spurious_key_update", 32'(key), 32'(last_key));
                else begin
                    e = q.pop_front();
                    check_eq("event_is_key", 32'(e.is_err), 0);
                    check_eq("key_value", 32'(key), 32'(e.key));
                end
            end
            last_key = key;
            prev_err = err;
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (10) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - 10) @(posedge clk);
    endtask

    // Send the first nbits of an 11-bit frame.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
        if (bad_par || bad_stop) model_err();
        else model_byte(b);
        send_frame(b, bad_par, bad_stop, 11);
        ps2_dat = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic glitch();
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] specials [9] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
        logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        rst_n   = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        #1 check_eq("reset_key", 32'(key), 0);
        check_eq("reset_err", 32'(err), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        mon_en = 1;

        send_byte(8'h16);
        check_eq("make_16", 32'(key), 32'h616);
        send_byte(8'hF0);
        check_eq("no_update_on_F0", 32'(key), 32'h616);
        send_byte(8'h16);
        check_eq("break_16", 32'(key), 32'h016);
        send_byte(8'hE0);
        send_byte(8'h75);
        check_eq("ext_75", 32'(key), 32'h775);
        send_byte(8'h75);
        check_eq("plain_75", 32'(key), 32'h275);

        send_byte(8'h1E, 1, 0);
        check_eq("parity_err_key_kept", 32'(key), 32'h275);
        // Break prefix stalled after 4 data bits until the timeout fires.
        model_err();
        send_frame(8'hF0, 0, 0, 5);
        repeat (TO + 200) @(posedge clk);
        ps2_dat = 1'b1;
        repeat (20) @(posedge clk);
        send_byte(8'h1E);
        check_eq("after_timeout_1E", 32'(key), 32'h61E);

        foreach (pause_seq[i]) send_byte(pause_seq[i]);
        check_eq("pause_swallowed", 32'(key), 32'h61E);
        send_byte(8'h26);
        check_eq("after_pause_26", 32'(key), 32'h226);

        glitch();
        send_byte(8'hAA);
        check_eq("glitch_bat_no_output", 32'(key), 32'h226);
        send_byte(8'h1C);
        check_eq("after_glitch_1C", 32'(key), 32'h61C);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            if ($urandom_range(0, 9) == 0) glitch();
            if ($urandom_range(0, 3) == 0) b = specials[$urandom_range(0, 8)];
            else b = 8'($urandom);
            send_byte(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end
        // Finish any pending Pause skip so the model and DUT are aligned.
        while (m_skip > 0) send_byte(8'h11);
        check_eq("random_final_key", 32'(key), 32'(m_key));

        // Reset in the middle of a frame.
        send_frame(8'h3C, 0, 0, 6);
        rst_n = 1'b0;
        model_reset();
        q.delete();
        repeat (5) @(posedge clk);
        ps2_dat = 1'b1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_eq("midframe_reset_key", 32'(key), 0);
        send_byte(8'h16);
        check_eq("after_reset_16", 32'(key), 32'h616);

        repeat (100) @(posedge clk);
        check_eq("scoreboard_drained", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
